// File: rtl/fp_pkg.sv
// Shared binary32 field widths, constants and accumulator FSM states.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0]  FP_POS_ZERO = 32'h00000000;
    localparam logic [EXP_W-1:0] FP_EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    function automatic logic is_inf(input logic [FP_W-1:0] x);
        return (x[FP_W-2:MAN_W] == FP_EXP_MAX) && (x[MAN_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/fpAdder.sv
// Combinational binary32 adder: round-to-nearest-even, gradual underflow,
// IEEE infinities, quiet-NaN output for any NaN or inf-inf.
module fpAdder
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] n1,
    input  logic [FP_W-1:0] n2,
    output logic [FP_W-1:0] sum
);

    logic             nan_a, nan_b, inf_a, inf_b, a_big, sub, rnd_up;
    logic [FP_W-1:0]  big, sml;
    logic [EXP_W-1:0] e_big, e_sml, diff, lim;
    logic [MAN_W:0]   m_big, m_sml, mant;
    logic [4:0]       sh, lz, shl;
    logic [50:0]      wide;
    logic [26:0]      l27, s27, norm;
    logic [27:0]      raw;
    logic [24:0]      m_rnd;
    logic [9:0]       e_norm, e_fin;

    always_comb begin
        nan_a = (n1[30:23] == FP_EXP_MAX) && (n1[22:0] != '0);
        nan_b = (n2[30:23] == FP_EXP_MAX) && (n2[22:0] != '0);
        inf_a = is_inf(n1);
        inf_b = is_inf(n2);

        // Order by magnitude so the subtraction below never goes negative
        a_big = n1[30:0] >= n2[30:0];
        big   = a_big ? n1 : n2;
        sml   = a_big ? n2 : n1;
        sub   = big[31] ^ sml[31];

        e_big = (big[30:23] == '0) ? 8'd1 : big[30:23];
        e_sml = (sml[30:23] == '0) ? 8'd1 : sml[30:23];
        m_big = {big[30:23] != '0, big[22:0]};
        m_sml = {sml[30:23] != '0, sml[22:0]};

        // Align with guard/round bits; everything shifted further folds into a sticky bit
        diff = e_big - e_sml;
        sh   = (diff > 8'd27) ? 5'd27 : diff[4:0];
        wide = {m_sml, 27'b0} >> sh;
        s27  = {wide[50:25], wide[24] | (|wide[23:0])};
        l27  = {m_big, 3'b000};
        raw  = sub ? ({1'b0, l27} - {1'b0, s27}) : ({1'b0, l27} + {1'b0, s27});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw[i]) lz = 5'(26 - i);
        end

        // Left shift stops at exponent 1, leaving a denormal
        lim = e_big - 8'd1;
        shl = ({3'b000, lz} > lim) ? lim[4:0] : lz;

        if (raw[27]) begin
            norm   = {raw[27:2], raw[1] | raw[0]};
            e_norm = {2'b00, e_big} + 10'd1;
        end else begin
            norm   = raw[26:0] << shl;
            e_norm = {2'b00, e_big} - {5'b00000, shl};
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        m_rnd  = {1'b0, norm[26:3]} + {24'b0, rnd_up};
        mant   = m_rnd[24] ? m_rnd[24:1] : m_rnd[23:0];
        e_fin  = m_rnd[24] ? e_norm + 10'd1 : e_norm;

        if (nan_a || nan_b) begin
            sum = 32'h7FC00000;
        end else if (inf_a && inf_b) begin
            sum = (n1[31] == n2[31]) ? n1 : 32'h7FC00000;
        end else if (inf_a) begin
            sum = n1;
        end else if (inf_b) begin
            sum = n2;
        end else if (raw == '0) begin
            sum = {sub ? 1'b0 : big[31], 31'b0};
        end else if (e_fin >= 10'd255) begin
            sum = {big[31], FP_EXP_MAX, 23'b0};
        end else begin
            sum = {big[31], mant[23] ? e_fin[7:0] : 8'h00, mant[22:0]};
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Streams a packet of binary32 values through fpAdder into a running sum and
// returns total, element count and a sticky infinity flag per packet.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_inf
);

    state_t           state, state_nx;
    logic [FP_W-1:0]  acc, add_sum;
    logic [CNT_W-1:0] count;
    logic             inf, beat, xfer;

    fpAdder u_add (
        .n1  (acc),
        .n2  (in_data),
        .sum (add_sum)
    );

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        state_nx  = state;
        case (state)
            IDLE, ACCUM: if (in_valid && in_last) state_nx = OUT;
                         else if (in_valid)       state_nx = ACCUM;
            OUT: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        beat = in_valid && in_ready;
        xfer = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst || xfer) begin
            acc   <= FP_POS_ZERO;
            count <= '0;
            inf   <= 1'b0;
        end else if (beat && state == IDLE) begin
            // First element loads directly; the adder only sees later ones
            acc   <= in_data;
            count <= CNT_W'(1);
            inf   <= is_inf(in_data);
        end else if (beat) begin
            acc   <= add_sum;
            count <= (count == '1) ? count : count + CNT_W'(1);
            inf   <= inf | is_inf(add_sum);
        end
    end

    assign out_sum   = acc;
    assign out_count = count;
    assign out_inf   = inf;

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench: directed packets plus random packets checked against an
// exact fixed-point reference rounded to binary32 after every addition.
module tb_fp_accumulator;

    localparam int CW = 4;

    typedef struct {
        logic [31:0] sum;
        int          cnt;
        logic        inf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_sum;
    logic [CW-1:0] out_count;
    logic          out_inf;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   bp_en = 1'b0;
    exp_t sb[$];

    fp_accumulator #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_inf   (out_inf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Value as a signed integer count of 2^-30 units (exact for the stimulus range)
    function automatic longint to_fixed(input logic [31:0] b);
        longint m, v;
        int     sh;
        if (b[30:0] == '0) return 0;
        m  = longint'({1'b1, b[22:0]});
        sh = int'(b[30:23]) - 120;
        v  = (sh >= 0) ? (m <<< sh) : (m >>> (-sh));
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] to_bits(input longint v);
        logic              s;
        longint unsigned   a, q, rem, half;
        int                p, sh;
        if (v == 0) return 32'h0;
        s = (v < 0);
        a = s ? longint'(-v) : v;
        p = 0;
        for (int i = 0; i < 64; i++) if (a[i]) p = i;
        if (p > 23) begin
            sh   = p - 23;
            q    = a >> sh;
            rem  = a & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p++;
            end
        end else begin
            q = a << (23 - p);
        end
        return {s, 8'(p + 97), q[22:0]};
    endfunction

    task automatic push(input logic [31:0] s, input int c, input logic f);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.inf = f;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        out_ready = v;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got sum %h with empty scoreboard", out_sum);
                end else begin
                    e = sb.pop_front();
                    check("out_sum", out_sum, e.sum);
                    check("out_count", 32'(out_count), 32'(e.cnt));
                    check("out_inf", 32'(out_inf), 32'(e.inf));
                end
            end
        end
    end

    initial begin : bp_gen
        forever begin
            @(posedge clk);
            #2;
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        longint acc_m;
        int     len, n;
        logic [31:0] x;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'h0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_inf", 32'(out_inf), 32'd0);
        rst = 1'b0;

        push(32'h4472B800, 2, 1'b0);
        send(32'h41C10000, 1'b0);
        send(32'h446CB000, 1'b1);

        push(32'h41C10000, 1, 1'b0);
        send(32'h41C10000, 1'b1);

        push(32'h430EA000, 3, 1'b0);
        send(32'h40880000, 1'b0);
        send(32'hC0840000, 1'b0);
        send(32'h430E8000, 1'b1);

        push(32'h7F800000, 2, 1'b1);
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b1);

        // Result parked under backpressure must hold steady
        set_ready(1'b0);
        push(32'h40880000, 1, 1'b0);
        send(32'h40880000, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_sum", out_sum, 32'h40880000);
            check("bp_out_count", 32'(out_count), 32'd1);
        end
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("post_xfer_in_ready", 32'(in_ready), 32'd1);

        push(32'h3E000000, 2, 1'b0);
        send(32'h40880000, 1'b0);
        send(32'hC0840000, 1'b1);

        // Reset in the middle of a packet discards it
        send(32'h40880000, 1'b0);
        send(32'h430E8000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        push(32'h40880000, 1, 1'b0);
        send(32'h40880000, 1'b1);

        // Random packets, lengths past counter saturation, random backpressure
        bp_en = 1'b1;
        for (int p = 0; p < 30; p++) begin
            len   = $urandom_range(1, 20);
            acc_m = 0;
            for (int k = 0; k < len; k++) begin
                x = {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
                acc_m = to_fixed(to_bits(acc_m + to_fixed(x)));
                if (k == len - 1)
                    push(to_bits(acc_m), (len > (1 << CW) - 1) ? (1 << CW) - 1 : len, 1'b0);
                send(x, k == len - 1);
            end
        end
        bp_en = 1'b0;
        set_ready(1'b1);

        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Streaming sequential front/back-end for the team's combinational single-precision adder `fpAdder` (ports n1, n2, sum).
- Accepts a packet of IEEE-754 binary32 values over a valid/ready input and feeds each value into `fpAdder` against a running-sum register.
- Captures each `fpAdder.sum` into that register.
- Presents the packet total, element count and an overflow flag over a valid/ready output.

Parameters:
- CNT_W, 16, width of element counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a beat
- in_data  input  32  binary32 operand
- in_last  input  1  final element of the packet
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  32  binary32 packet total
- out_count  output  CNT_W  number of elements accepted in the packet
- out_inf  output  1  sticky: running sum reached ±infinity (exp=8'hFF, mantissa=0)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE; acc=32'h0; count=0; inf=0.
  - in_ready=1; out_valid=0; out_sum=0; out_count=0; out_inf=0.
- Beat transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- FSM states: IDLE, ACCUM, OUT.
  - IDLE: in_ready=1. On a beat: acc<=in_data (direct load, bypasses the adder); count<=1; inf<=(in_data is ±inf). Next state: OUT if in_last, else ACCUM.
  - ACCUM: in_ready=1. On a beat: acc<=fpAdder(n1=acc, n2=in_data).sum; count<=sat(count+1); inf<=inf | (new sum is ±inf). Next state: OUT if in_last, else stay. With no beat: hold all state.
  - OUT: in_ready=0; out_valid=1. out_sum=acc, out_count=count and out_inf=inf are held stable while out_ready=0. On output transfer: acc<=0, count<=0, inf<=0, next state IDLE.
- Latency: the result is visible one cycle after the in_last beat. With out_ready held high, back-to-back packets lose exactly one input cycle (the OUT cycle).
- Throughput: one element per cycle in IDLE/ACCUM. The adder path is combinational from acc and in_data to the acc D-input.
- Operand order: acc is always n1 and in_data is always n2. The adder is order-independent, so this choice does not affect results.
- Saturation: count stops at 2^CNT_W-1. The inf flag is sticky for the whole packet.
- in_valid low mid-packet: the FSM waits indefinitely in ACCUM; no timeout.
- rst asserted in any state, including mid-packet or in OUT with out_valid=1: returns to reset values next edge. The partial packet is discarded and out_valid drops.
- in_data/in_last are ignored whenever in_ready=0.
- NaN, denormal and rounding behaviour are exactly those of `fpAdder`; this block adds no special handling.

Decomposition:
- Package fp_pkg:
  - FP_W=32, EXP_W=8, MAN_W=23.
  - FP_POS_ZERO=32'h00000000; FP_EXP_MAX=8'hFF.
  - function is_inf(x).
  - state enum {IDLE, ACCUM, OUT}.
- Sub-module: one instance of the existing `fpAdder`. No other sub-modules; the FSM, counter and flag logic are inline.

Test Plan:
- Two-element packet: 24.125 (32'h41C10000), then 946.75 (32'h446CB000, last); out_ready=1 -> one cycle after last: out_sum=32'h4472B800 (970.875), out_count=2, out_inf=0.
- Single element: 32'h41C10000 with last -> out_sum=32'h41C10000, out_count=1. The adder is not used.
- Three-element mixed sign: 4.25 (32'h40880000), -4.125 (32'hC0840000), 142.5 (32'h430E8000, last) -> out_sum=32'h430EA000 (142.625), out_count=3.
- Overflow: 32'h7F7FFFFF twice (last on second) -> out_sum=32'h7F800000, out_inf=1.
- Backpressure, then a second packet:
  - Hold out_ready=0 for 5 cycles: out_valid=1, in_ready=0, outputs stable.
  - Raise out_ready: output transfers, next cycle in_ready=1.
  - Send 4.25 then -4.125 (last) -> out_sum=32'h3E000000 (0.125), out_count=2.
- Reset mid-packet: send 4.25, 142.5 without last; assert rst for one cycle -> next cycle in_ready=1, out_valid=0, count=0. A following single-beat packet 32'h40880000 (last) yields out_sum=32'h40880000, out_count=1.
